// File: rtl/arm_pkg.sv
// Shared constants, the LDM/STM sequencer state encoding and the addressing modes.
// The addressing mode is the pair {P, U} taken from the instruction.
package arm_pkg;

   localparam int WORD_SIZE  = 32;
   localparam int NUM_REGS   = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEXT,
      S_RDWAIT,
      S_MEM,
      S_LDWR,
      S_WB,
      S_DONE
   } seq_state_t;

   localparam logic [1:0] MODE_DA = 2'b00;
   localparam logic [1:0] MODE_IA = 2'b01;
   localparam logic [1:0] MODE_DB = 2'b10;
   localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/reg_list_scan.sv
// Combinational register-list scan: index of the lowest set bit, a flag that the list
// is non-empty, and the number of set bits. The decode stage also uses this block.
module reg_list_scan
   import arm_pkg::*;
(
   input  logic [NUM_REGS-1:0]   list,
   output logic [ADDR_WIDTH-1:0] low_idx,
   output logic                  low_vld,
   output logic [CNT_WIDTH-1:0]  count
);

   // Walking from the top down lets the lowest set bit win the last assignment.
   always_comb begin
      low_idx = '0;
      low_vld = 1'b0;
      count   = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (list[i]) begin
            low_idx = ADDR_WIDTH'(i);
            low_vld = 1'b1;
         end
         count = count + CNT_WIDTH'(list[i]);
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, moving each register between the
// single-port register file and a req/ack memory port, then optionally writes back the base.
module ldm_stm_sequencer
   import arm_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load,
   input  logic                  pre,
   input  logic                  up,
   input  logic                  wb,
   input  logic [NUM_REGS-1:0]   reg_list,
   input  logic [WORD_SIZE-1:0]  base,
   input  logic [ADDR_WIDTH-1:0] base_reg,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rf_read_addr,
   input  logic [WORD_SIZE-1:0]  rf_read_data,
   output logic                  rf_we,
   output logic [ADDR_WIDTH-1:0] rf_write_addr,
   output logic [WORD_SIZE-1:0]  rf_write_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [WORD_SIZE-1:0]  mem_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   input  logic                  mem_ack
);

   seq_state_t            state, state_nxt, finish_state;
   logic [NUM_REGS-1:0]   list_q, scan_list, list_rest;
   logic                  load_q, do_wb_q, last;
   logic [ADDR_WIDTH-1:0] base_reg_q, low_idx;
   logic [WORD_SIZE-1:0]  addr_q, wb_val_q, data_q;
   logic [WORD_SIZE-1:0]  span, start_addr;
   logic                  low_vld;
   logic [CNT_WIDTH-1:0]  count;

   // In IDLE the scanner sizes the incoming list; afterwards it tracks the remaining bits.
   assign scan_list = (state == S_IDLE) ? reg_list : list_q;

   reg_list_scan u_scan (
      .list    (scan_list),
      .low_idx (low_idx),
      .low_vld (low_vld),
      .count   (count)
   );

   assign span         = WORD_SIZE'(count) << 2;
   assign list_rest    = list_q & ~(NUM_REGS'(1) << low_idx);
   assign last         = (list_rest == '0);
   assign finish_state = do_wb_q ? S_WB : S_DONE;

   always_comb begin
      unique case ({pre, up})
         MODE_IA: start_addr = base;
         MODE_IB: start_addr = base + WORD_SIZE'(4);
         MODE_DA: start_addr = base - span + WORD_SIZE'(4);
         default: start_addr = base - span;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = low_vld ? S_NEXT : S_DONE;
         S_NEXT:   state_nxt = load_q ? S_MEM : S_RDWAIT;
         S_RDWAIT: state_nxt = S_MEM;
         S_MEM: begin
            if (mem_ack) begin
               if (load_q)    state_nxt = S_LDWR;
               else if (last) state_nxt = finish_state;
               else           state_nxt = S_NEXT;
            end
         end
         S_LDWR:   state_nxt = last ? finish_state : S_NEXT;
         S_WB:     state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // An LDM that reloads its own base keeps the loaded value, so writeback is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         list_q     <= '0;
         load_q     <= 1'b0;
         do_wb_q    <= 1'b0;
         base_reg_q <= '0;
         addr_q     <= '0;
         wb_val_q   <= '0;
         data_q     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  list_q     <= reg_list;
                  load_q     <= load;
                  do_wb_q    <= wb & ~(load & reg_list[base_reg]);
                  base_reg_q <= base_reg;
                  addr_q     <= start_addr;
                  wb_val_q   <= up ? (base + span) : (base - span);
               end
            end
            S_RDWAIT: data_q <= rf_read_data;
            S_MEM: begin
               if (mem_ack) begin
                  addr_q <= addr_q + WORD_SIZE'(4);
                  if (load_q) data_q <= mem_rdata;
                  else        list_q <= list_rest;
               end
            end
            S_LDWR:  list_q <= list_rest;
            default: ;
         endcase
      end
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign mem_req       = (state == S_MEM);
   assign mem_we        = (state == S_MEM) & ~load_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = data_q;
   assign rf_read_addr  = (state == S_IDLE) ? '0 : low_idx;
   assign rf_we         = (state == S_LDWR) | (state == S_WB);
   assign rf_write_addr = (state == S_LDWR) ? low_idx : base_reg_q;
   assign rf_write_data = (state == S_WB) ? wb_val_q : data_q;

endmodule
